// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//
// Direct-mapped instruction cache sitting between the fetch stage and a
// 128-bit-block instruction memory. A lookup hit returns the instruction in
// the same cycle. A miss stalls fetch, reads the whole block from memory and
// then re-evaluates the request, which hits.
//
// Ports:
//   CLK           clock, all state changes on posedge
//   RESET         asynchronous active-low reset
//   READ          fetch request valid
//   ADDRESS       byte address of the instruction (bits [1:0] ignored)
//   INSTRUCTION   instruction word, valid when READ=1 and BUSYWAIT=0
//   BUSYWAIT      stall to the fetch stage
//   MEM_READ      block read request to instruction memory
//   MEM_ADDRESS   block address ADDRESS[31:4] of the missing line
//   MEM_READDATA  refill block, word k in bits [32k+31:32k]
//   MEM_BUSYWAIT  memory busy; data valid in a cycle where it is low
//   HIT_COUNT     (ICACHE_STATS_EN only) saturating count of lookup hits
//   MISS_COUNT    (ICACHE_STATS_EN only) saturating count of refills started
//
// Parameters:
//   LINES          number of cache lines (power of 2, at least 2)
//   MEM_LAT_CHECK  when nonzero, a simulation check flags a memory that
//                  answers in the first refill cycle
//
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss counters.
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
  parameter int LINES         = 8,
  parameter int MEM_LAT_CHECK = 0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t             state_r;
  logic [LINES-1:0]   valid_r;
  logic [TW-1:0]      tag_r  [LINES];
  logic [127:0]       data_r [LINES];
  logic [27:0]        miss_addr_r;
  logic               mem_read_r;
  logic [31:0]        instr_r;

  logic [IW-1:0]      index_s;
  logic [TW-1:0]      tag_s;
  logic [1:0]         offset_s;
  logic [127:0]       line_s;
  logic [31:0]        word_s;
  logic               hit_s;
  logic               refill_done_s;
  logic [IW-1:0]      fill_index_s;
  logic [TW-1:0]      fill_tag_s;
  logic               unused_s;

  assign index_s      = ADDRESS[4 +: IW];
  assign tag_s        = ADDRESS[31 -: TW];
  assign offset_s     = ADDRESS[3:2];
  assign fill_index_s = miss_addr_r[IW-1:0];
  assign fill_tag_s   = miss_addr_r[27 -: TW];
  assign line_s       = data_r[index_s];
  // Byte-offset bits are not needed for word-aligned fetches.
  assign unused_s     = ^ADDRESS[1:0];

  // Lookup: word select and combinational hit detection, only meaningful in IDLE.
  always_comb begin
    word_s = 32'h0;
    hit_s  = 1'b0;
    case (offset_s)
      2'd0:    word_s = line_s[31:0];
      2'd1:    word_s = line_s[63:32];
      2'd2:    word_s = line_s[95:64];
      2'd3:    word_s = line_s[127:96];
      default: word_s = 32'h0;
    endcase
    if ((state_r == IDLE) && READ && valid_r[index_s] && (tag_r[index_s] == tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  assign refill_done_s = (state_r == REFILL) && !MEM_BUSYWAIT;

  // A hit forwards the array word directly; otherwise the last delivered word holds.
  assign INSTRUCTION = hit_s ? word_s : instr_r;
  // Gated by RESET so the stall drops asynchronously with reset, like MEM_READ.
  assign BUSYWAIT    = RESET & ((state_r == REFILL) | (READ & ~hit_s));
  assign MEM_READ    = mem_read_r;
  assign MEM_ADDRESS = miss_addr_r;

  // Control FSM: miss detection, refill tracking, valid bits and held instruction.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= IDLE;
      valid_r     <= {LINES{1'b0}};
      miss_addr_r <= 28'h0;
      mem_read_r  <= 1'b0;
      instr_r     <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            instr_r <= word_s;
          end else if (READ) begin
            // Block address is frozen here so later ADDRESS changes cannot disturb the refill.
            state_r     <= REFILL;
            miss_addr_r <= ADDRESS[31:4];
            mem_read_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        REFILL: begin
          if (!MEM_BUSYWAIT) begin
            valid_r[fill_index_s] <= 1'b1;
            mem_read_r            <= 1'b0;
            state_r               <= IDLE;
          end else begin
            state_r <= REFILL;
          end
        end
        default: begin
          state_r    <= IDLE;
          mem_read_r <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: data and tag are written unconditionally on refill completion (evicting any occupant).
  always_ff @(posedge CLK) begin
    if (refill_done_s) begin
      data_r[fill_index_s] <= MEM_READDATA;
      tag_r[fill_index_s]  <= fill_tag_s;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Saturating hit and miss counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count_r  <= 32'h0;
      miss_count_r <= 32'h0;
    end else begin
      if (hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end else begin
        hit_count_r <= hit_count_r;
      end
      if ((state_r == IDLE) && READ && !hit_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end else begin
        miss_count_r <= miss_count_r;
      end
    end
  end

  assign HIT_COUNT  = hit_count_r;
  assign MISS_COUNT = miss_count_r;
`endif

  if (MEM_LAT_CHECK != 0) begin : g_lat_check
    // The memory must still be busy in the first cycle MEM_READ is seen high.
    a_min_latency: assert property (@(posedge CLK) disable iff (!RESET)
                                    $rose(MEM_READ) |-> MEM_BUSYWAIT)
      else $error("instruction memory answered in the first refill cycle");
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// Testbench for icache_fetch_responder. Directed scenarios (cold miss, same
// line hits, conflict eviction, address change mid-refill, reset mid-refill)
// followed by randomized fetches, all checked against a line-level model of
// a direct-mapped cache and a synthetic memory whose contents are a pure
// function of the block address.
// -----------------------------------------------------------------------------
module tb_icache_fetch_responder;

  localparam int LINES = 8;
  localparam int TAG_SHIFT = 4 + $clog2(LINES);

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  int          vectors;
  int          miscompares;
  int          mem_lat;
  logic        ref_valid [LINES];
  logic [31:0] ref_tag   [LINES];
  logic [31:0] last_instr;
  int          ref_hits;
  int          ref_misses;

  icache_fetch_responder #(.LINES(LINES), .MEM_LAT_CHECK(1)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory contents: block 0 holds 0x11,0x22,0x33,0x44 (word0..word3).
  function automatic logic [31:0] mem_word(input logic [27:0] blk, input int k);
    return (32'(blk) * 32'h0100_0193) ^ (32'(k + 1) * 32'h0000_0011);
  endfunction

  // Memory responder: busy for mem_lat cycles of a request, then one data cycle.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = 128'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_READ === 1'b1) begin
        cnt++;
        if (cnt > mem_lat) begin
          MEM_BUSYWAIT = 1'b0;
          MEM_READDATA = {mem_word(MEM_ADDRESS, 3), mem_word(MEM_ADDRESS, 2),
                          mem_word(MEM_ADDRESS, 1), mem_word(MEM_ADDRESS, 0)};
        end else begin
          MEM_BUSYWAIT = 1'b1;
        end
      end else begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 32'h0;
    end
    last_instr = 32'h0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  function automatic logic model_miss(input logic [31:0] a);
    int idx;
    idx = int'((a >> 4) % LINES);
    return !(ref_valid[idx] && (ref_tag[idx] == (a >> TAG_SHIFT)));
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int idx;
    idx = int'((a >> 4) % LINES);
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = a >> TAG_SHIFT;
  endtask

  // Called at the negedge of the lookup cycle for address a; follows any refill to the hit.
  task automatic fetch_finish(input logic [31:0] a);
    logic        exp_miss;
    logic [31:0] exp_w;
    int          n;
    exp_miss = model_miss(a);
    exp_w    = mem_word(a[31:4], int'(a[3:2]));
    check("busy_on_request", BUSYWAIT, exp_miss);
    check("mem_read_in_lookup", MEM_READ, 32'd0);
    n = 0;
    while (BUSYWAIT === 1'b1 && n < 40) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      n++;
      if (BUSYWAIT === 1'b1) begin
        check("mem_read_during_refill", MEM_READ, 32'd1);
        check("mem_address_during_refill", MEM_ADDRESS, a[31:4]);
      end
    end
    check("stall_cycles", n, exp_miss ? mem_lat + 2 : 0);
    check("instruction", INSTRUCTION, exp_w);
    check("mem_read_after", MEM_READ, 32'd0);
    model_fill(a);
    last_instr = exp_w;
    ref_hits++;
    if (exp_miss) ref_misses++;
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    READ    = 1'b1;
    ADDRESS = a;
    @(negedge CLK);
    fetch_finish(a);
  endtask

  task automatic idle_step(input logic [31:0] a);
    READ    = 1'b0;
    ADDRESS = a;
    @(negedge CLK);
    check("idle_busy", BUSYWAIT, 32'd0);
    check("idle_instruction_hold", INSTRUCTION, last_instr);
    check("idle_mem_read", MEM_READ, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin : stimulus
    int          n;
    int          r;
    logic [31:0] a;
    vectors     = 0;
    miscompares = 0;
    mem_lat     = 3;
    READ        = 1'b0;
    ADDRESS     = 32'h0;
    RESET       = 1'b0;
    model_reset();

    // Reset state.
    #2;
    check("reset_instruction", INSTRUCTION, 32'h0);
    check("reset_busy", BUSYWAIT, 32'd0);
    check("reset_mem_read", MEM_READ, 32'd0);
    check("reset_mem_address", MEM_ADDRESS, 32'h0);
    READ = 1'b1;
    #1;
    check("reset_busy_with_read", BUSYWAIT, 32'd0);
    READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    idle_step(32'h0);

    // 1: cold miss on 0x0 with 3 busy memory cycles.
    fetch(32'h0000_0000);
    // 2: hits on the rest of the line.
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_000C);
`ifdef ICACHE_STATS_EN
    check("stats_hits_after_t2", HIT_COUNT, 32'd4);
    check("stats_misses_after_t2", MISS_COUNT, 32'd1);
`endif

    // 3: conflict eviction in index 0.
    mem_lat = 2;
    fetch(32'h0000_0080);
    fetch(32'h0000_0000);

    // 4: address changes while the refill for 0x10 is in flight.
    mem_lat = 3;
    READ    = 1'b1;
    ADDRESS = 32'h0000_0010;
    @(negedge CLK);
    check("t4_busy_on_miss", BUSYWAIT, 32'd1);
    @(posedge CLK);
    #1;
    ADDRESS = 32'h0000_0020;
    @(negedge CLK);
    n = 0;
    while (MEM_READ === 1'b1 && n < 40) begin
      check("t4_mem_address_held", MEM_ADDRESS, 32'h1);
      check("t4_busy_in_refill", BUSYWAIT, 32'd1);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      n++;
    end
    check("t4_refill_cycles", n, mem_lat + 1);
    model_fill(32'h0000_0010);
    ref_misses++;
    fetch_finish(32'h0000_0020);
    fetch(32'h0000_0010);
    fetch(32'h0000_0014);

    // 5: reset in the middle of a refill.
    READ    = 1'b1;
    ADDRESS = 32'h0000_0030;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("t5_refill_started", MEM_READ, 32'd1);
    #1;
    RESET = 1'b0;
    #1;
    check("t5_mem_read_async", MEM_READ, 32'd0);
    check("t5_busy_async", BUSYWAIT, 32'd0);
    check("t5_mem_address_async", MEM_ADDRESS, 32'h0);
    check("t5_instruction_async", INSTRUCTION, 32'h0);
    READ = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    idle_step(32'h0000_0030);
    fetch(32'h0000_0000);
    fetch(32'h0000_0030);

    // Randomized fetches over a small address window to mix hits, misses and conflicts.
    for (int i = 0; i < 60; i++) begin
      mem_lat = $urandom_range(1, 4);
      r = $urandom_range(0, 9);
      a = (32'($urandom_range(0, 3)) << TAG_SHIFT) | (32'($urandom_range(0, LINES - 1)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (r == 0) begin
        idle_step(a);
      end else if (r == 1) begin
        fetch(32'hFFFF_FFFC);
      end else begin
        fetch(a);
      end
    end
    fetch(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFF0);
`ifdef ICACHE_STATS_EN
    check("stats_hits_final", HIT_COUNT, ref_hits);
    check("stats_misses_final", MISS_COUNT, ref_misses);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
Instruction-side responder for the fetch stage. It accepts the fetch stage's PC-driven read requests and returns a 32-bit instruction, asserting busywait on a miss. Organisation is a direct-mapped instruction cache backed by a 128-bit-block instruction memory. It sits between the fetch stage (drives READ/ADDRESS, stalls on BUSYWAIT) and the main instruction memory (MEM_* handshake).

Parameters:
LINES, 8, number of cache lines; power of 2, minimum 2; index width IW = log2(LINES).
MEM_LAT_CHECK, 0, if 1, a simulation-only $error fires when MEM_BUSYWAIT is low in the first refill cycle (memory must take at least 1 cycle); no RTL effect.

Ports:
CLK  in  1  clock; all state changes on posedge.
RESET  in  1  asynchronous, active-low reset.
READ  in  1  fetch request valid.
ADDRESS  in  32  byte address of the instruction; bits[1:0] ignored.
INSTRUCTION  out  32  instruction word; valid when READ=1 and BUSYWAIT=0.
BUSYWAIT  out  1  stall to the fetch stage.
MEM_READ  out  1  block read request to instruction memory.
MEM_ADDRESS  out  28  block address (ADDRESS[31:4] of the missing line).
MEM_READDATA  in  128  refill block; word k in bits[32k+31:32k].
MEM_BUSYWAIT  in  1  memory busy; data valid on the cycle it is low while MEM_READ=1.

Behaviour:
- Address split: offset = ADDRESS[3:2] (word select), index = ADDRESS[4+IW-1:4], tag = ADDRESS[31:4+IW].
- Per-line storage: valid bit, tag, 128-bit data. Reset (RESET=0, async) clears all valid bits, forces state IDLE, and drives MEM_READ=0, BUSYWAIT=0, MEM_ADDRESS=0, INSTRUCTION=0. Data and tag arrays are not cleared.
- FSM states are IDLE and REFILL.
- IDLE behaviour:
  - Hit = READ & valid[index] & (tag match). Hit is combinational.
  - On a hit: INSTRUCTION = selected word and BUSYWAIT=0 in the same cycle, giving 0-cycle added latency.
  - On a miss (READ & !hit): BUSYWAIT=1 combinationally. At the next posedge, latch ADDRESS[31:4] into the miss register and go to REFILL.
  - With READ=0: BUSYWAIT=0, INSTRUCTION holds its last value.
- REFILL behaviour:
  - MEM_READ=1, MEM_ADDRESS = latched block address, BUSYWAIT=1.
  - On the first posedge where MEM_BUSYWAIT=0:
    - write MEM_READDATA into the line indexed by the latched address;
    - set its tag and valid bit;
    - deassert MEM_READ in the following cycle;
    - return to IDLE.
  - The request is then re-evaluated in IDLE and hits, so a miss costs memory latency + 2 cycles.
- MEM_READ/MEM_ADDRESS stay stable for the whole refill regardless of ADDRESS or READ changes.
- A refill, once started, always completes, even if READ drops. After refill, if ADDRESS changed, a new lookup occurs and may miss again.
- Address 0xFFFFFFFC (fetch PC after reset) is a normal address: index/tag computed as usual.
- Asynchronous reset during REFILL aborts immediately: MEM_READ=0 and no line is written.
- Conflict: the refill overwrites the valid line at that index unconditionally.
- No write path; the block is read-only.

Optional Feature:
Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments on each posedge with IDLE & READ & hit; MISS_COUNT increments on each IDLE→REFILL transition.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: no ports and no counter logic.

Test Plan:
1. Cold miss: reset, then READ=1, ADDRESS=0x00000000, memory returns block {0x44,0x33,0x22,0x11} (word3..word0) after 3 busy cycles.
   - Required response: BUSYWAIT=1 immediately, MEM_READ=1 with MEM_ADDRESS=0x0000000.
   - After MEM_BUSYWAIT low: BUSYWAIT falls 1 cycle after the refill edge, INSTRUCTION=0x11.
2. Same-line hits: ADDRESS 0x4, 0x8, 0xC after test 1 → BUSYWAIT=0 every cycle; INSTRUCTION=0x22, 0x33, 0x44; MEM_READ stays 0.
3. Conflict eviction (LINES=8): ADDRESS=0x80 (same index 0, tag 1) → miss, MEM_ADDRESS=0x0000008. Then ADDRESS=0x0 misses again.
4. Address change mid-refill: miss on 0x10, switch ADDRESS to 0x20 while MEM_BUSYWAIT=1.
   - Required: MEM_ADDRESS stays 0x0000001; line 1 is filled.
   - Required: 0x20 then triggers its own miss with MEM_ADDRESS=0x0000002.
5. Reset mid-refill: assert RESET=0 during REFILL → MEM_READ=0 and BUSYWAIT=0 asynchronously. Re-access of the previously cached 0x0 misses.
6. ICACHE_STATS_EN defined: run tests 1–2 → MISS_COUNT=1, HIT_COUNT=4 (post-refill hit + 3).
